// File: rtl/dpram_stream_reader.sv
// Read-side sequencer for a dual-port BRAM: turns (addr, len) commands into BRAM reads
// and streams the returned words out over AXI-Stream, with a credit-managed output FIFO.
module dpram_stream_reader #(
    parameter  int unsigned DATA_WIDTH = 36,
    parameter  int unsigned RAM_DEPTH  = 1024,
    parameter  int unsigned RD_LATENCY = 2,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AW-1:0]         cmd_addr,
    input  logic [AW-1:0]         cmd_len,
    output logic [AW-1:0]         ram_addr,
    output logic                  ram_en,
    output logic                  ram_regce,
    output logic                  ram_rst,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam int unsigned RW = AW + 1;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dpram_stream_reader: RD_LATENCY must be 1 or 2");
    end
    if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("dpram_stream_reader: FIFO_DEPTH must be at least RD_LATENCY+1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [RD_LATENCY-1:0] pv_q, pl_q;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         occ;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] dmem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] lmem_q;

    logic credit_ok;
    logic issue;
    logic issue_last;
    logic fifo_wr;
    logic fifo_wr_last;
    logic pop;
    logic cmd_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_wr      = pv_q[RD_LATENCY-1];
    assign fifo_wr_last = pl_q[RD_LATENCY-1];
    assign m_tvalid     = (count_q != '0);
    assign pop          = m_tvalid && m_tready;
    assign m_tdata      = m_tvalid ? dmem_q[rd_ptr_q] : '0;
    assign m_tlast      = m_tvalid && lmem_q[rd_ptr_q];
    assign busy         = (state_q != ST_IDLE);

    // Occupancy counts reads still in the BRAM pipe plus words buffered, less this cycle's pop.
    assign occ       = inflight_q + count_q - CW'(pop);
    assign credit_ok = (occ < CW'(FIFO_DEPTH));

    assign ram_addr  = addr_q;
    assign ram_en    = issue;
    assign ram_regce = 1'b1;
    assign ram_rst   = rstb;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        cmd_ready  = (state_q == ST_IDLE) && !rstb;
        cmd_hs     = cmd_valid && cmd_ready;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    state_d = ST_READ;
                    addr_d  = cmd_addr;
                    rem_d   = {1'b0, cmd_len} + RW'(1);
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (rem_q == RW'(1));
                    rem_d      = rem_q - RW'(1);
                    addr_d     = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q + CW'(issue) - CW'(fifo_wr);
        count_d    = count_q + CW'(fifo_wr) - CW'(pop);
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (fifo_wr) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // The {valid,last} tag rides alongside the BRAM read so the FIFO knows when ram_dout is real.
    always_ff @(posedge clka) begin
        if (rstb) begin
            pv_q <= '0;
            pl_q <= '0;
        end else begin
            pv_q[0] <= issue;
            pl_q[0] <= issue_last;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (fifo_wr) begin
            dmem_q[wr_ptr_q] <= ram_dout;
            lmem_q[wr_ptr_q] <= fifo_wr_last;
        end
    end

    a_fifo_bounded: assert property (@(posedge clka) disable iff (rstb)
        count_q <= CW'(FIFO_DEPTH));
    a_no_overflow: assert property (@(posedge clka) disable iff (rstb)
        !(fifo_wr && !pop && count_q == CW'(FIFO_DEPTH)));

endmodule
